// File: rtl/snake_game_sequencer.sv
// rtl/snake_game_sequencer.sv - snake game-flow sequencer (optional feature macro: SPEEDUP_EN)
module snake_game_sequencer #(
    parameter logic [24:0] TICK_BASE = 25'd30_000_000,
    parameter logic [24:0] TICK_MIN  = 25'd10_000_000,
    parameter logic [24:0] TICK_STEP = 25'd1_000_000,
    parameter logic [6:0]  MAX_SCORE = 7'd99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       eat,
    input  logic       collide,
    input  logic       food_ack,
    output logic [1:0] state,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic       grow,
    output logic       restart,
    output logic       food_req,
    output logic       game_over,
    output logic [6:0] score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_n;
    logic        start_d;
    logic        pause_d;
    logic        start_edge;
    logic        pause_edge;
    logic [24:0] counter;
    logic [24:0] period;
    logic        period_end;
    logic        eat_pending;
    logic [1:0]  pending_dir;
    logic        do_restart;
    logic        count_en;
    logic        tick_fire;
    logic        btn_valid;
    logic [1:0]  btn_dir;
    logic        dir_update;

    // Move period after a score change; 32-bit math so the subtraction clamps at TICK_MIN.
    function automatic logic [24:0] speed_period(input logic [6:0] s);
        logic [31:0] reduction;
        reduction = 32'(s) * 32'(TICK_STEP);
        if (reduction + 32'(TICK_MIN) >= 32'(TICK_BASE))
            return TICK_MIN;
        else
            return 25'(32'(TICK_BASE) - reduction);
    endfunction

    assign start_edge = start & ~start_d;
    assign pause_edge = pause & ~pause_d;
    assign period_end = (counter == period - 25'd1);
    assign state      = state_q;

    // Next-state and per-cycle control strobes; collide pre-empts a pending tick.
    always_comb begin
        state_n    = state_q;
        do_restart = 1'b0;
        count_en   = 1'b0;
        tick_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_n    = PLAY;
                    do_restart = 1'b1;
                end
            end
            PLAY: begin
                if (collide) begin
                    state_n = OVER;
                end else begin
                    count_en  = 1'b1;
                    tick_fire = period_end;
                    if (pause_edge)
                        state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_edge)
                    state_n = PLAY;
            end
            OVER: begin
                if (start_edge) begin
                    state_n    = PLAY;
                    do_restart = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Button priority up>down>left>right; reversing the committed direction is ignored.
    always_comb begin
        btn_valid = 1'b1;
        btn_dir   = 2'd0;
        if (up)
            btn_dir = 2'd1;
        else if (down)
            btn_dir = 2'd2;
        else if (left)
            btn_dir = 2'd3;
        else if (right)
            btn_dir = 2'd0;
        else
            btn_valid = 1'b0;
        dir_update = (state_q == PLAY) && btn_valid && (btn_dir != ~dir);
    end

    // Game state register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    // Counter, direction, score, pulses and the food respawn handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_d     <= 1'b0;
            pause_d     <= 1'b0;
            counter     <= 25'd0;
            period      <= TICK_BASE;
            score       <= 7'd0;
            dir         <= 2'd0;
            pending_dir <= 2'd0;
            eat_pending <= 1'b0;
            move_tick   <= 1'b0;
            grow        <= 1'b0;
            restart     <= 1'b0;
            food_req    <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_d   <= start;
            pause_d   <= pause;
            move_tick <= tick_fire;
            grow      <= tick_fire & eat_pending;
            restart   <= do_restart;
            game_over <= (state_n == OVER);

            // A fresh grow re-arms the request even if an old one is being acked.
            if (grow)
                food_req <= 1'b1;
            else if (food_req && food_ack)
                food_req <= 1'b0;

            if (do_restart) begin
                counter     <= 25'd0;
                period      <= TICK_BASE;
                score       <= 7'd0;
                dir         <= 2'd0;
                pending_dir <= 2'd0;
                eat_pending <= 1'b0;
            end else begin
                if (count_en)
                    counter <= tick_fire ? 25'd0 : counter + 25'd1;

                if (tick_fire)
                    dir <= pending_dir;

                if (tick_fire && eat_pending) begin
                    eat_pending <= 1'b0;
                    if (score != MAX_SCORE) begin
                        score <= score + 7'd1;
`ifdef SPEEDUP_EN
                        period <= speed_period(score + 7'd1);
`else
                        period <= TICK_BASE;
`endif
                    end
                end else if (eat && !food_req) begin
                    eat_pending <= 1'b1;
                end

                if (dir_update)
                    pending_dir <= btn_dir;
            end
        end
    end

endmodule

// File: tb/tb_snake_game_sequencer.sv
// tb/tb_snake_game_sequencer.sv - directed self-checking bench for snake_game_sequencer
module tb_snake_game_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, pause, up, down, left, right, eat, collide, food_ack;
    logic [1:0] state, dir;
    logic       move_tick, grow, restart, food_req, game_over;
    logic [6:0] score;

    int errors = 0;
    int checks = 0;

    // Move period once score is 1.
`ifdef SPEEDUP_EN
    localparam int P1 = 8;
`else
    localparam int P1 = 10;
`endif

    snake_game_sequencer #(
        .TICK_BASE(25'd10),
        .TICK_MIN (25'd4),
        .TICK_STEP(25'd2),
        .MAX_SCORE(7'd99)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .up(up), .down(down), .left(left), .right(right),
        .eat(eat), .collide(collide), .food_ack(food_ack),
        .state(state), .dir(dir), .move_tick(move_tick), .grow(grow),
        .restart(restart), .food_req(food_req), .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles && n < 0; i++) begin
            tick();
            if (move_tick === 1'b1)
                n = i;
        end
    endtask

    task automatic test_reset();
        logic [4:0] pulses;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        pulses = {move_tick, grow, restart, food_req, game_over};
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", dir); end
        checks++; if (score !== 7'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++; if (pulses !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", pulses); end
        pause = 1'b1; tick(); pause = 1'b0;
        collide = 1'b1; tick(); collide = 1'b0;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_ignores_pause_collide: got %0d expected 0", state); end
    endtask

    task automatic test_start_tick();
        int n;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        checks++; if (restart !== 1'b1) begin errors++; $display("FAIL start_restart: got %0d expected 1", restart); end
        tick();
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_once: got %0d expected 0", restart); end
        wait_tick(20, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL first_tick_delay: got %0d expected 9", n); end
        wait_tick(20, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL tick_period: got %0d expected 10", n); end
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL start_dir: got %0d expected 0", dir); end
    endtask

    task automatic test_direction();
        int n;
        left = 1'b1; repeat (3) tick(); left = 1'b0;
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL reverse_left_ignored: got %0d expected 0", dir); end
        up = 1'b1; tick(); up = 1'b0;
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL dir_before_tick: got %0d expected 0", dir); end
        wait_tick(20, n);
        checks++; if (n !== 6) begin errors++; $display("FAIL dir_tick_delay: got %0d expected 6", n); end
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL dir_up_on_tick: got %0d expected 1", dir); end
        down = 1'b1; tick(); down = 1'b0;
        wait_tick(20, n);
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL reverse_down_ignored: got %0d expected 1", dir); end
        up = 1'b1; right = 1'b1; tick(); up = 1'b0; right = 1'b0;
        wait_tick(20, n);
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL up_over_right_priority: got %0d expected 1", dir); end
        right = 1'b1; tick(); right = 1'b0;
        wait_tick(20, n);
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL dir_right_on_tick: got %0d expected 0", dir); end
    endtask

    task automatic test_eat();
        int n;
        eat = 1'b1; tick(); eat = 1'b0;
        wait_tick(20, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL eat_tick_delay: got %0d expected 9", n); end
        checks++; if (grow !== 1'b1) begin errors++; $display("FAIL eat_grow: got %0d expected 1", grow); end
        checks++; if (score !== 7'd1) begin errors++; $display("FAIL eat_score: got %0d expected 1", score); end
        checks++; if (food_req !== 1'b0) begin errors++; $display("FAIL food_req_early: got %0d expected 0", food_req); end
        tick();
        checks++; if (food_req !== 1'b1) begin errors++; $display("FAIL food_req_rise: got %0d expected 1", food_req); end
        checks++; if (grow !== 1'b0) begin errors++; $display("FAIL grow_one_cycle: got %0d expected 0", grow); end
        repeat (4) tick();
        checks++; if (food_req !== 1'b1) begin errors++; $display("FAIL food_req_held: got %0d expected 1", food_req); end
        food_ack = 1'b1; tick(); food_ack = 1'b0;
        checks++; if (food_req !== 1'b0) begin errors++; $display("FAIL food_req_drop: got %0d expected 0", food_req); end
        wait_tick(20, n);
        checks++; if (n !== P1 - 6) begin errors++; $display("FAIL post_eat_tick: got %0d expected %0d", n, P1 - 6); end
        checks++; if (grow !== 1'b0 || score !== 7'd1) begin errors++; $display("FAIL no_second_grow: got grow=%0d score=%0d expected grow=0 score=1", grow, score); end
    endtask

    task automatic test_pause();
        int n;
        int ticks_seen;
        repeat (6) tick();
        pause = 1'b1; tick(); pause = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_enter: got %0d expected 2", state); end
        ticks_seen = 0;
        down = 1'b1;
        repeat (50) begin
            tick();
            if (move_tick === 1'b1) ticks_seen++;
        end
        down = 1'b0;
        checks++; if (ticks_seen !== 0) begin errors++; $display("FAIL pause_no_ticks: got %0d expected 0", ticks_seen); end
        collide = 1'b1; tick(); collide = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_ignores_collide: got %0d expected 2", state); end
        pause = 1'b1; tick(); pause = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pause_exit: got %0d expected 1", state); end
        // Counter froze at 7 (the pause-edge cycle still counted), so P1-7 more cycles remain.
        wait_tick(20, n);
        checks++; if (n !== P1 - 7) begin errors++; $display("FAIL resume_tick: got %0d expected %0d", n, P1 - 7); end
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL pause_ignores_buttons: got %0d expected 0", dir); end
    endtask

    task automatic test_collide();
        int n;
        eat = 1'b1; tick(); eat = 1'b0;
        repeat (P1 - 2) tick();
        collide = 1'b1; tick(); collide = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL collide_state: got %0d expected 3", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL collide_game_over: got %0d expected 1", game_over); end
        checks++; if (move_tick !== 1'b0 || grow !== 1'b0) begin errors++; $display("FAIL collide_suppress: got tick=%0d grow=%0d expected 0 0", move_tick, grow); end
        checks++; if (score !== 7'd1) begin errors++; $display("FAIL collide_score: got %0d expected 1", score); end
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_hold: got %0d expected 3", state); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (restart !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL over_restart: got restart=%0d state=%0d expected 1 1", restart, state); end
        checks++; if (score !== 7'd0 || game_over !== 1'b0 || dir !== 2'd0) begin errors++; $display("FAIL over_clear: got score=%0d go=%0d dir=%0d expected 0 0 0", score, game_over, dir); end
        wait_tick(20, n);
        checks++; if (n !== 10 || grow !== 1'b0) begin errors++; $display("FAIL restart_tick: got n=%0d grow=%0d expected 10 0", n, grow); end
    endtask

    task automatic test_back_to_back();
        int n;
        int exp_iv [5];
`ifdef SPEEDUP_EN
        exp_iv = '{10, 8, 6, 4, 4};
`else
        exp_iv = '{10, 10, 10, 10, 10};
`endif
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) eat = 1'b1;
            tick();
            eat = 1'b0;
            food_ack = 1'b1; tick(); food_ack = 1'b0;
            wait_tick(30, n);
            checks++; if (n + 2 !== exp_iv[k]) begin errors++; $display("FAIL interval_%0d: got %0d expected %0d", k, n + 2, exp_iv[k]); end
            checks++; if (score !== 7'((k < 4) ? k + 1 : 4) || grow !== (k < 4)) begin errors++; $display("FAIL score_grow_%0d: got score=%0d grow=%0d", k, score, grow); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        eat = 1'b1; tick(); eat = 1'b0;
        wait_tick(30, n);
        tick();
        checks++; if (food_req !== 1'b1) begin errors++; $display("FAIL mid_food_req: got %0d expected 1", food_req); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (food_req !== 1'b0 || state !== 2'd0 || score !== 7'd0) begin errors++; $display("FAIL mid_reset: got req=%0d state=%0d score=%0d expected 0 0 0", food_req, state, score); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; up = 1'b0; down = 1'b0;
        left = 1'b0; right = 1'b0; eat = 1'b0; collide = 1'b0; food_ack = 1'b0;
        test_reset();
        test_start_tick();
        test_direction();
        test_eat();
        test_pause();
        test_collide();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
